// File: rtl/sphy_lanes_if.sv
// Controller-side bundle of the SPI slave PHY: mode controls, TX ready/valid
// byte stream and RX byte strobe.
interface sphy_lanes_if;
  logic       c_ck;
  logic       c_en;
  logic [1:0] c_width;
  logic       c_ddr;
  logic       c_oe;
  logic [7:0] c_tx_data;
  logic       c_tx_valid;
  logic       c_tx_ready;
  logic [7:0] c_rx_data;
  logic       c_rx_valid;

  modport master (
    input  c_ck, c_en, c_tx_ready, c_rx_data, c_rx_valid,
    output c_width, c_ddr, c_oe, c_tx_data, c_tx_valid
  );

  modport slave (
    output c_ck, c_en, c_tx_ready, c_rx_data, c_rx_valid,
    input  c_width, c_ddr, c_oe, c_tx_data, c_tx_valid
  );
endinterface

// File: rtl/sphy_lanes.sv
// SPI slave PHY: 1/2/4-lane SDR/DDR byte serialiser/deserialiser clocked
// from the pad clock, with controller-side ready/valid TX and strobed RX.
module sphy_lanes #(
  parameter int LANES = 4
) (
  input  logic             p_ck,
  input  logic             p_nrst,
  input  logic             p_ncs,
  output logic [LANES-1:0] p_se,
  output logic [LANES-1:0] p_so,
  input  logic [LANES-1:0] p_si,
  sphy_lanes_if.slave      ctl
);
  localparam logic [1:0] WL_MAX  = (LANES >= 4) ? 2'd2 : (LANES >= 2) ? 2'd1 : 2'd0;
  localparam int         RX_LANE = (LANES >= 2) ? 1 : 0;

  // Lane width is carried as log2(w): 0 -> 1 lane, 1 -> 2 lanes, 2 -> 4 lanes.
  function automatic logic [1:0] clamp_wl(input logic [1:0] width);
    logic [1:0] wl;
    wl = (width == 2'd3) ? 2'd2 : width;
    return (wl > WL_MAX) ? WL_MAX : wl;
  endfunction

  function automatic logic [2:0] last_beat(input logic [1:0] wl, input logic ddr);
    logic [2:0] r;
    case ({wl, ddr})
      3'b000:         r = 3'd7;
      3'b001, 3'b010: r = 3'd3;
      3'b011, 3'b100: r = 3'd1;
      default:        r = 3'd0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] wl);
    logic [3:0] r;
    case (wl)
      2'd0:    r = 4'b0001;
      2'd1:    r = 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  // Receive lanes, most significant lane first; single-lane mode listens on lane 1 when present.
  function automatic logic [3:0] lane_bits(input logic [1:0] wl, input logic [3:0] pads);
    logic [3:0] r;
    case (wl)
      2'd0:    r = {3'b000, pads[RX_LANE]};
      2'd1:    r = {2'b00, pads[1:0]};
      default: r = pads;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] top_bits(input logic [1:0] wl, input logic [7:0] v);
    logic [3:0] r;
    case (wl)
      2'd0:    r = {3'b000, v[7]};
      2'd1:    r = {2'b00, v[7:6]};
      default: r = v[7:4];
    endcase
    return r;
  endfunction

  function automatic logic [7:0] shift_in(input logic [7:0] d, input logic [3:0] n,
                                          input logic [7:0] bits);
    return (d << n) | bits;
  endfunction

  logic             en, bnd, is_last, rx_done;
  logic [2:0]       cnt;
  logic [1:0]       m_wl, cur_wl, pend_wl;
  logic             m_ddr, cur_ddr;
  logic [3:0]       cur_w, cur_b, m_w, pend_w2;
  logic [3:0]       si4, sample, se_full, so4;
  logic [3:0]       hi_p0, lo_n1, so_lo_n1;
  logic [7:0]       tx_sh, tx_lo, rx_sh, rx_pair, rx_acc, rx_base, rx_next, rx_data_q;
  logic             rx_valid_q, pend, pend_last;
  logic [LANES-1:0] se_q;

  // At the byte boundary the new mode comes straight from the controller.
  assign en      = ~p_ncs;
  assign bnd     = (cnt == 3'd0);
  assign cur_wl  = bnd ? clamp_wl(ctl.c_width) : m_wl;
  assign cur_ddr = bnd ? ctl.c_ddr : m_ddr;
  assign is_last = (cnt == last_beat(cur_wl, cur_ddr));
  assign cur_w   = 4'd1 << cur_wl;
  assign cur_b   = cur_w << cur_ddr;
  assign m_w     = 4'd1 << m_wl;
  assign pend_w2 = 4'd2 << pend_wl;
  assign si4     = 4'(p_si);
  assign sample  = lane_bits(cur_wl, si4);
  assign se_full = ctl.c_oe ? lane_mask(cur_wl) : 4'b0000;
  assign tx_lo   = tx_sh << m_w;

  // A DDR beat is posedge half then retimed negedge half, folded in one posedge late.
  assign rx_pair = (8'(hi_p0) << (4'd1 << pend_wl)) | 8'(lo_n1);
  assign rx_acc  = shift_in(rx_sh, pend_w2, rx_pair);
  assign rx_base = pend ? rx_acc : rx_sh;
  assign rx_next = cur_ddr ? rx_base : shift_in(rx_base, cur_w, 8'(sample));
  assign rx_done = (pend & pend_last) | (~cur_ddr & is_last);

  // posedge stage: beat counter, mode capture, TX shift, RX assembly
  always_ff @(posedge p_ck or negedge p_nrst) begin
    if (!p_nrst) begin
      cnt        <= 3'd0;
      m_wl       <= 2'd0;
      m_ddr      <= 1'b0;
      se_q       <= '0;
      tx_sh      <= 8'h00;
      rx_sh      <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      hi_p0      <= 4'h0;
      pend       <= 1'b0;
      pend_last  <= 1'b0;
      pend_wl    <= 2'd0;
    end else if (!en) begin
      cnt        <= 3'd0;
      pend       <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      cnt <= is_last ? 3'd0 : cnt + 3'd1;
      if (bnd) begin
        m_wl  <= cur_wl;
        m_ddr <= cur_ddr;
        se_q  <= se_full[LANES-1:0];
        tx_sh <= ctl.c_tx_valid ? ctl.c_tx_data : 8'hFF;
      end else begin
        tx_sh <= tx_sh << cur_b;
      end
      rx_sh      <= rx_next;
      rx_valid_q <= rx_done;
      if (rx_done) rx_data_q <= (pend & pend_last) ? rx_acc : rx_next;
      hi_p0     <= sample;
      pend      <= cur_ddr;
      pend_last <= is_last;
      pend_wl   <= cur_wl;
    end
  end

  // negedge stage: lower DDR half for both directions
  always_ff @(negedge p_ck or negedge p_nrst) begin
    if (!p_nrst) begin
      lo_n1    <= 4'h0;
      so_lo_n1 <= 4'h0;
    end else if (en) begin
      lo_n1    <= lane_bits(m_wl, si4);
      so_lo_n1 <= top_bits(m_wl, tx_lo);
    end
  end

  assign so4            = (m_ddr && !p_ck) ? so_lo_n1 : top_bits(m_wl, tx_sh);
  assign p_so           = so4[LANES-1:0];
  assign p_se           = se_q;
  assign ctl.c_ck       = p_ck;
  assign ctl.c_en       = en;
  assign ctl.c_tx_ready = en & bnd;
  assign ctl.c_rx_data  = rx_data_q;
  assign ctl.c_rx_valid = rx_valid_q;
endmodule

// File: tb/tb_sphy_lanes.sv
// Bench for sphy_lanes: directed vector table, randomized bytes against a
// bit-stream model, plus chip-select abort and async reset sequences.
module tb_sphy_lanes;
  localparam int LANES   = 4;
  localparam int RX_LANE = 1;

  logic             p_ck = 1'b0;
  logic             p_nrst, p_ncs;
  logic [LANES-1:0] p_se, p_so, p_si;

  sphy_lanes_if ctl();

  sphy_lanes #(.LANES(LANES)) dut (
    .p_ck  (p_ck),
    .p_nrst(p_nrst),
    .p_ncs (p_ncs),
    .p_se  (p_se),
    .p_so  (p_so),
    .p_si  (p_si),
    .ctl   (ctl)
  );

  always #5 p_ck = ~p_ck;

  typedef struct {
    logic [1:0] width;
    logic       ddr;
    logic       oe;
    logic       txv;
    logic [7:0] txd;
    logic [7:0] rxd;
    logic [3:0] se;
    int         beats;
  } vec_t;

  vec_t       tbl[8];
  int         n_checks, n_pass;
  logic       pend;
  logic [7:0] prev_rx;
  logic [1:0] r_width;
  logic       r_ddr, r_oe, r_txv;
  logic [7:0] r_txd, r_rxd;
  int         r_w, r_b;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
  endtask

  function automatic int eff_lanes(input logic [1:0] width);
    int w;
    w = (width == 2'd0) ? 1 : (width == 2'd1) ? 2 : 4;
    return (w > LANES) ? LANES : w;
  endfunction

  function automatic int bmask(input int n);
    return (1 << n) - 1;
  endfunction

  function automatic logic [3:0] pads_of(input int val, input int w);
    return (w == 1) ? 4'(val << RX_LANE) : 4'(val);
  endfunction

  task automatic scramble_ctrl();
    ctl.c_width    = 2'($urandom);
    ctl.c_ddr      = 1'($urandom);
    ctl.c_oe       = 1'($urandom);
    ctl.c_tx_valid = 1'($urandom);
    ctl.c_tx_data  = 8'($urandom);
  endtask

  // One byte, entered and left in the p_ck low phase. Bits stream MSB first,
  // beat k carries bits [7-k*b -: b]; the upper w bits go out while p_ck is high.
  task automatic do_byte(input logic [1:0] width, input logic ddr, input logic oe,
                         input logic txv, input logic [7:0] txd, input logic [7:0] rxd,
                         input logic [3:0] exp_se, input int nbeats);
    int w, b, tv, v, rv;
    w  = eff_lanes(width);
    b  = ddr ? 2 * w : w;
    tv = txv ? int'(txd) : 255;
    ctl.c_width    = width;
    ctl.c_ddr      = ddr;
    ctl.c_oe       = oe;
    ctl.c_tx_valid = txv;
    ctl.c_tx_data  = txd;
    check("tx_ready_boundary", 8'(ctl.c_tx_ready), 8'd1);
    for (int k = 0; k < nbeats; k++) begin
      v  = (tv >> (8 - (k + 1) * b)) & bmask(b);
      rv = (int'(rxd) >> (8 - (k + 1) * b)) & bmask(b);
      p_si = pads_of(ddr ? (rv >> w) : rv, w);
      @(posedge p_ck); #2;
      check("so_high", 8'(p_so), 8'(ddr ? (v >> w) : v));
      check("se", 8'(p_se), 8'(exp_se));
      if (k == 0 && pend) begin
        check("rx_valid_ddr", 8'(ctl.c_rx_valid), 8'd1);
        check("rx_data_ddr", ctl.c_rx_data, prev_rx);
      end else if (!ddr && k == nbeats - 1) begin
        check("rx_valid_sdr", 8'(ctl.c_rx_valid), 8'd1);
        check("rx_data_sdr", ctl.c_rx_data, rxd);
      end else begin
        check("rx_valid_idle", 8'(ctl.c_rx_valid), 8'd0);
      end
      check("tx_ready_beat", 8'(ctl.c_tx_ready), 8'(k == nbeats - 1));
      if (k == 0) check("c_ck", 8'(ctl.c_ck), 8'd1);
      scramble_ctrl();
      if (ddr) p_si = pads_of(rv & bmask(w), w);
      @(negedge p_ck); #2;
      check("so_low", 8'(p_so), 8'(ddr ? (v & bmask(w)) : v));
    end
    pend    = ddr;
    prev_rx = rxd;
  endtask

  // Chip-select pulse at a byte boundary; any DDR byte still pending is lost.
  task automatic drop_cs();
    p_ncs = 1'b1;
    #1;
    check("c_en_off", 8'(ctl.c_en), 8'd0);
    @(posedge p_ck); #2;
    check("cs_rx_valid", 8'(ctl.c_rx_valid), 8'd0);
    check("cs_tx_ready", 8'(ctl.c_tx_ready), 8'd0);
    @(negedge p_ck); #2;
    p_ncs = 1'b0;
    #1;
    check("cs_ready_back", 8'(ctl.c_tx_ready), 8'd1);
    pend = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    pend     = 1'b0;
    prev_rx  = 8'h00;
    tbl[0] = '{2'd0, 1'b0, 1'b1, 1'b1, 8'hA5, 8'hB2, 4'h1, 8};
    tbl[1] = '{2'd2, 1'b1, 1'b1, 1'b1, 8'h3C, 8'h96, 4'hF, 1};
    tbl[2] = '{2'd1, 1'b0, 1'b1, 1'b1, 8'h12, 8'h5A, 4'h3, 4};
    tbl[3] = '{2'd1, 1'b0, 1'b1, 1'b1, 8'h34, 8'hC3, 4'h3, 4};
    tbl[4] = '{2'd2, 1'b0, 1'b0, 1'b0, 8'h77, 8'hE1, 4'h0, 2};
    tbl[5] = '{2'd3, 1'b1, 1'b1, 1'b1, 8'h81, 8'h7E, 4'hF, 1};
    tbl[6] = '{2'd0, 1'b1, 1'b1, 1'b1, 8'hC6, 8'h39, 4'h1, 4};
    tbl[7] = '{2'd1, 1'b1, 1'b0, 1'b1, 8'hD2, 8'h4B, 4'h0, 2};

    p_nrst = 1'b0;
    p_ncs  = 1'b1;
    p_si   = '0;
    ctl.c_width    = 2'd0;
    ctl.c_ddr      = 1'b0;
    ctl.c_oe       = 1'b0;
    ctl.c_tx_valid = 1'b0;
    ctl.c_tx_data  = 8'h00;
    #12;
    check("rst_se", 8'(p_se), 8'h00);
    check("rst_so", 8'(p_so), 8'h00);
    check("rst_rx_valid", 8'(ctl.c_rx_valid), 8'd0);
    check("rst_rx_data", ctl.c_rx_data, 8'h00);
    check("rst_tx_ready_cs_high", 8'(ctl.c_tx_ready), 8'd0);
    p_nrst = 1'b1;
    p_ncs  = 1'b0;
    #1;
    check("tx_ready_after_rst", 8'(ctl.c_tx_ready), 8'd1);
    check("c_en_on", 8'(ctl.c_en), 8'd1);

    for (int i = 0; i < 8; i++)
      do_byte(tbl[i].width, tbl[i].ddr, tbl[i].oe, tbl[i].txv, tbl[i].txd, tbl[i].rxd,
              tbl[i].se, tbl[i].beats);

    for (int i = 0; i < 150; i++) begin
      r_width = 2'($urandom);
      r_ddr   = 1'($urandom);
      r_oe    = 1'($urandom);
      r_txv   = ($urandom_range(3) != 0);
      r_txd   = 8'($urandom);
      r_rxd   = 8'($urandom);
      r_w     = eff_lanes(r_width);
      r_b     = r_ddr ? 2 * r_w : r_w;
      do_byte(r_width, r_ddr, r_oe, r_txv, r_txd, r_rxd, r_oe ? 4'(bmask(r_w)) : 4'h0, 8 / r_b);
      if ($urandom_range(9) == 0) drop_cs();
    end

    // Chip select lost after three of eight single-lane beats.
    drop_cs();
    ctl.c_width    = 2'd0;
    ctl.c_ddr      = 1'b0;
    ctl.c_oe       = 1'b1;
    ctl.c_tx_valid = 1'b1;
    ctl.c_tx_data  = 8'h5A;
    for (int j = 0; j < 3; j++) begin
      p_si = 4'(2);
      @(posedge p_ck); #2;
      check("abort_rx_valid", 8'(ctl.c_rx_valid), 8'd0);
      @(negedge p_ck); #2;
    end
    p_ncs = 1'b1;
    @(posedge p_ck); #2;
    check("abort_rx_valid_cs", 8'(ctl.c_rx_valid), 8'd0);
    check("abort_tx_ready_cs", 8'(ctl.c_tx_ready), 8'd0);
    @(negedge p_ck); #2;
    p_ncs = 1'b0;
    #1;
    check("abort_cnt_restart", 8'(ctl.c_tx_ready), 8'd1);
    do_byte(2'd0, 1'b0, 1'b1, 1'b1, 8'hC3, 8'h3C, 4'h1, 8);

    // Async reset right after a completed quad SDR byte.
    ctl.c_width    = 2'd2;
    ctl.c_ddr      = 1'b0;
    ctl.c_oe       = 1'b1;
    ctl.c_tx_valid = 1'b1;
    ctl.c_tx_data  = 8'hFF;
    p_si = 4'hA;
    @(posedge p_ck); #2;
    check("pre_rst_so", 8'(p_so), 8'h0F);
    check("pre_rst_se", 8'(p_se), 8'h0F);
    p_si = 4'h5;
    @(negedge p_ck); #2;
    @(posedge p_ck); #2;
    check("pre_rst_rx_valid", 8'(ctl.c_rx_valid), 8'd1);
    check("pre_rst_rx_data", ctl.c_rx_data, 8'hA5);
    p_nrst = 1'b0;
    #1;
    check("async_rst_se", 8'(p_se), 8'h00);
    check("async_rst_so", 8'(p_so), 8'h00);
    check("async_rst_rx_valid", 8'(ctl.c_rx_valid), 8'd0);
    check("async_rst_rx_data", ctl.c_rx_data, 8'h00);
    check("async_rst_tx_ready", 8'(ctl.c_tx_ready), 8'd1);
    @(negedge p_ck); #2;
    p_nrst = 1'b1;
    pend   = 1'b0;
    do_byte(2'd1, 1'b1, 1'b1, 1'b1, 8'h6E, 8'h91, 4'h3, 2);
    do_byte(2'd0, 1'b0, 1'b0, 1'b1, 8'h0F, 8'hF0, 4'h0, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
